// File: rtl/ysyx_22050133_divider.sv
// ysyx_22050133_divider: iterative radix-2 restoring divider for the EXU.
// Implements DIV/DIVU/REM/REMU and their W forms. It produces one quotient bit
// per clock, MSB first, and returns the quotient and remainder together.
// Divide-by-zero and signed overflow bypass the loop and finish in one cycle.
module ysyx_22050133_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic            r_ready;
  logic            r_outValid;
  logic [XLEN-1:0] r_quotient;
  logic [XLEN-1:0] r_remainder;
  logic [5:0]      r_counter;
  logic            r_divw;
  logic            r_signQ;
  logic            r_signR;
  logic [XLEN-1:0] r_divisorMag;
  logic [XLEN-1:0] r_dividendShift;
  logic [XLEN-1:0] r_partRem;
  logic [XLEN-1:0] r_quotAcc;

  logic            w_accept;
  logic [XLEN-1:0] w_opA;
  logic [XLEN-1:0] w_opB;
  logic            w_negA;
  logic            w_negB;
  logic [XLEN-1:0] w_magA;
  logic [XLEN-1:0] w_magB;
  logic [XLEN-1:0] w_minNeg;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_specQ;
  logic [XLEN-1:0] w_specR;

  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_qNext;
  logic [XLEN-1:0] w_qSigned;
  logic [XLEN-1:0] w_rSigned;
  logic [XLEN-1:0] w_qFinal;
  logic [XLEN-1:0] w_rFinal;
  logic            w_lastIter;

  assign div_ready = r_ready;
  assign out_valid = r_outValid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

  // A request is taken only when idle and ready. A flush in the same cycle wins.
  assign w_accept = (r_state == IDLE) && div_valid && r_ready && !flush;

  // Operand preparation: W ops keep the low word, sign- or zero-extended.
  always_comb begin
    w_opA = dividend;
    w_opB = divisor;
    if (divw) begin
      if (div_signed) begin
        w_opA = {{(XLEN-HALF){dividend[HALF-1]}}, dividend[HALF-1:0]};
        w_opB = {{(XLEN-HALF){divisor[HALF-1]}}, divisor[HALF-1:0]};
      end else begin
        w_opA = {{(XLEN-HALF){1'b0}}, dividend[HALF-1:0]};
        w_opB = {{(XLEN-HALF){1'b0}}, divisor[HALF-1:0]};
      end
    end
  end

  // The loop works on magnitudes. Signs are restored at completion.
  assign w_negA = div_signed && w_opA[XLEN-1];
  assign w_negB = div_signed && w_opB[XLEN-1];
  assign w_magA = w_negA ? (-w_opA) : w_opA;
  assign w_magB = w_negB ? (-w_opB) : w_opB;

  // Special cases are detected on the prepared, width-adjusted operands.
  assign w_minNeg   = divw ? {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
  assign w_divZero  = (w_opB == '0);
  assign w_overflow = div_signed && (w_opA == w_minNeg) && (&w_opB);
  assign w_special  = w_divZero || w_overflow;

  // Results for the special cases. W results are always sign-extended from bit 31.
  always_comb begin
    w_specQ = w_opA;
    w_specR = '0;
    if (w_divZero) begin
      w_specQ = '1;
      if (divw) begin
        w_specR = {{(XLEN-HALF){w_opA[HALF-1]}}, w_opA[HALF-1:0]};
      end else begin
        w_specR = w_opA;
      end
    end
  end

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted trial value is below twice the divisor. When the trial is
  // smaller than the divisor, the 65-bit difference wraps with bit 64 set.
  // When the trial is at least the divisor, the difference fits in 64 bits.
  // Bit 64 of the difference therefore acts as the inverted compare.
  assign w_trial   = {r_partRem, r_dividendShift[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_divisorMag};
  assign w_ge      = !w_diff[XLEN];
  assign w_remNext = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_qNext   = {r_quotAcc[XLEN-2:0], w_ge};

  // A W op runs 32 steps. A full-width op runs 64 steps.
  assign w_lastIter = (r_counter == (r_divw ? 6'd31 : 6'd63));

  // Sign fix-up on the final step. A zero remainder is never negated.
  assign w_qSigned = r_signQ ? (-w_qNext) : w_qNext;
  assign w_rSigned = (r_signR && (w_remNext != '0)) ? (-w_remNext) : w_remNext;
  assign w_qFinal  = r_divw ? {{(XLEN-HALF){w_qSigned[HALF-1]}}, w_qSigned[HALF-1:0]}
                            : w_qSigned;
  assign w_rFinal  = r_divw ? {{(XLEN-HALF){w_rSigned[HALF-1]}}, w_rSigned[HALF-1:0]}
                            : w_rSigned;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Flush overrides every other transition.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_valid && r_ready) begin
            w_nextState = w_special ? FIN : DIV;
          end
        end
        DIV: begin
          if (w_lastIter) begin
            w_nextState = IDLE;
          end
        end
        FIN: begin
          w_nextState = IDLE;
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Datapath and handshake: latch operands, iterate, publish results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready         <= 1'b0;
      r_outValid      <= 1'b0;
      r_quotient      <= '0;
      r_remainder     <= '0;
      r_counter       <= '0;
      r_divw          <= 1'b0;
      r_signQ         <= 1'b0;
      r_signR         <= 1'b0;
      r_divisorMag    <= '0;
      r_dividendShift <= '0;
      r_partRem       <= '0;
      r_quotAcc       <= '0;
    end else if (flush) begin
      r_outValid <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready      <= 1'b0;
            r_outValid   <= 1'b0;
            r_counter    <= '0;
            r_divw       <= divw;
            r_signQ      <= w_negA ^ w_negB;
            r_signR      <= w_negA;
            r_divisorMag <= w_magB;
            if (divw) begin
              r_dividendShift <= {w_magA[HALF-1:0], {(XLEN-HALF){1'b0}}};
            end else begin
              r_dividendShift <= w_magA;
            end
            // Special cases keep their ready-made results in the loop registers.
            r_partRem <= w_special ? w_specR : '0;
            r_quotAcc <= w_special ? w_specQ : '0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        DIV: begin
          r_partRem       <= w_remNext;
          r_quotAcc       <= w_qNext;
          r_dividendShift <= {r_dividendShift[XLEN-2:0], 1'b0};
          r_counter       <= r_counter + 6'd1;
          if (w_lastIter) begin
            r_quotient  <= w_qFinal;
            r_remainder <= w_rFinal;
            r_outValid  <= 1'b1;
            r_ready     <= 1'b1;
          end
        end
        FIN: begin
          r_quotient  <= r_quotAcc;
          r_remainder <= r_partRem;
          r_outValid  <= 1'b1;
          r_ready     <= 1'b1;
        end
        default: begin
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_divider.sv
// Directed testbench for ysyx_22050133_divider.
// Each vector checks the result values, the latency and the handshake,
// using hand-computed expectations.
module tb_ysyx_22050133_divider;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        div_valid;
  logic        divw;
  logic        div_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int checkCount = 0;
  int errorCount = 0;

  ysyx_22050133_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request, then check the handshake, the latency and the results.
  task automatic applyStimulus(input string tag, input logic w, input logic s,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] expQ, input logic [63:0] expR,
                               input int expLat);
    int  lat;
    int  readyHigh;
    bit  done;
    @(negedge clk);
    divw       = w;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    divw       = ~w;
    div_signed = ~s;
    dividend   = 64'hDEAD_BEEF_CAFE_F00D;
    divisor    = 64'h0;
    checkOutput({tag, " ready_drop"}, {63'b0, div_ready}, 64'd0);
    checkOutput({tag, " valid_clr"}, {63'b0, out_valid}, 64'd0);
    lat       = 0;
    readyHigh = 0;
    done      = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) done = 1'b1;
      else if (div_ready) readyHigh++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " ready_busy"}, 64'(readyHigh), 64'd0);
    checkOutput({tag, " quotient"}, quotient, expQ);
    checkOutput({tag, " remainder"}, remainder, expR);
    checkOutput({tag, " ready_done"}, {63'b0, div_ready}, 64'd1);
  endtask

  initial begin
    int risings;
    rst_n      = 1'b0;
    flush      = 1'b0;
    div_valid  = 1'b0;
    divw       = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst ready", {63'b0, div_ready}, 64'd0);
    checkOutput("rst valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst quotient", quotient, 64'd0);
    checkOutput("rst remainder", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release ready_low", {63'b0, div_ready}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_release ready_up", {63'b0, div_ready}, 64'd1);

    // Full-width operations.
    applyStimulus("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold valid", {63'b0, out_valid}, 64'd1);
    checkOutput("hold quotient", quotient, 64'd14);
    applyStimulus("div_m7_2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    applyStimulus("div_7_m2", 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64);
    applyStimulus("divu_max_16", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                  64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 64);
    applyStimulus("divu_max_maxm1", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 64);

    // Special cases.
    applyStimulus("div_by_zero", 1'b0, 1'b1, 64'h1234, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    applyStimulus("ovf64", 1'b0, 1'b1, 64'h8000_0000_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1);
    applyStimulus("ovfw", 1'b1, 1'b1, 64'hDEAD_0000_8000_0000,
                  64'h1234_5678_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);

    // W operations with junk in the upper operand bits.
    applyStimulus("divuw_junk", 1'b1, 1'b0, 64'hABCD_1234_FFFF_FFFF,
                  64'h5555_5555_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32);
    applyStimulus("divw_m20_3", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3,
                  64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 32);

    // A flush in IDLE blocks acceptance and clears out_valid.
    @(negedge clk);
    divw       = 1'b0;
    div_signed = 1'b0;
    dividend   = 64'd5;
    divisor    = 64'd1;
    div_valid  = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("idle_flush valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("idle_flush ready", {63'b0, div_ready}, 64'd1);

    // A flush ten cycles into a full-width op.
    @(negedge clk);
    dividend  = 64'd1000;
    divisor   = 64'd3;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush valid", {63'b0, out_valid}, 64'd0);
    checkOutput("flush ready", {63'b0, div_ready}, 64'd1);
    checkOutput("flush quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("flush remainder", remainder, 64'hFFFF_FFFF_FFFF_FFFE);
    risings = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) risings++;
    end
    checkOutput("flush no_result", 64'(risings), 64'd0);
    applyStimulus("after_flush_9_3", 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 64);

    // An asynchronous reset in the middle of an op.
    @(negedge clk);
    divw      = 1'b0;
    dividend  = 64'd100;
    divisor   = 64'd7;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst quotient", quotient, 64'd0);
    checkOutput("async_rst remainder", remainder, 64'd0);
    checkOutput("async_rst valid", {63'b0, out_valid}, 64'd0);
    checkOutput("async_rst ready", {63'b0, div_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("async_rst ready_up", {63'b0, div_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
